// File: rtl/dma_lsu_port_arbiter_pkg.sv
// rtl/dma_lsu_port_arbiter_pkg.sv - shared source encoding and tag-width helpers for the LSU/DMA port arbiter
package dma_lsu_port_arbiter_pkg;

    // Source bit carried in the MSB of the memory-side tag
    typedef enum logic {
        SRC_LSU = 1'b0,
        SRC_DMA = 1'b1
    } dma_arb_src_e;

    localparam int DMA_ARB_DEF_TAG_WIDTH = 8;
    localparam int DMA_ARB_TAG_W         = DMA_ARB_DEF_TAG_WIDTH + 1;

    // Memory-side tag width for a given requester tag width
    function automatic int dma_arb_tag_w(input int tag_width);
        return tag_width + 1;
    endfunction

endpackage

// File: rtl/dma_lsu_port_arbiter_req_buf.sv
// rtl/dma_lsu_port_arbiter_req_buf.sv - single-entry valid/ready pipeline register for the arbitrated request
module dma_arb_req_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_stage_ready;

    // The entry can be refilled when empty or when it drains this cycle
    assign w_stage_ready = ~r_valid | i_ready;
    assign o_ready       = w_stage_ready;
    assign o_valid       = r_valid;
    assign o_data        = r_data;

    // Valid flag; reset drops any held request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (w_stage_ready) begin
            r_valid <= i_valid;
        end
    end

    // Payload loads only on accept, so it stays stable during back-pressure
    always_ff @(posedge clk) begin
        if (w_stage_ready && i_valid) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/dma_lsu_port_arbiter.sv
// rtl/dma_lsu_port_arbiter.sv - LSU/DMA shared memory port arbiter; optional perf counters under DMA_ARB_PERF_EN
module dma_lsu_port_arbiter
    import dma_lsu_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int TAG_WIDTH       = 8,
    parameter int STARVE_LIMIT    = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic                    lsu_req_rw,
    input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_req_data,
    input  logic [DATA_WIDTH/8-1:0] lsu_req_byteen,
    input  logic [TAG_WIDTH-1:0]    lsu_req_tag,
    input  logic                    dma_req_valid,
    output logic                    dma_req_ready,
    input  logic                    dma_req_rw,
    input  logic [ADDR_WIDTH-1:0]   dma_req_addr,
    input  logic [DATA_WIDTH-1:0]   dma_req_data,
    input  logic [DATA_WIDTH/8-1:0] dma_req_byteen,
    input  logic [TAG_WIDTH-1:0]    dma_req_tag,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [TAG_WIDTH:0]      mem_req_tag,
    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH:0]      mem_rsp_tag,
    output logic                    lsu_rsp_valid,
    input  logic                    lsu_rsp_ready,
    output logic [DATA_WIDTH-1:0]   lsu_rsp_data,
    output logic [TAG_WIDTH-1:0]    lsu_rsp_tag,
    output logic                    dma_rsp_valid,
    input  logic                    dma_rsp_ready,
    output logic [DATA_WIDTH-1:0]   dma_rsp_data,
    output logic [TAG_WIDTH-1:0]    dma_rsp_tag
`ifdef DMA_ARB_PERF_EN
    ,
    output logic [43:0]             perf_lsu_grants,
    output logic [43:0]             perf_dma_grants,
    output logic [43:0]             perf_stall_cycles
`endif
);

    localparam int TAG_W = dma_arb_tag_w(TAG_WIDTH);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PAY_W = 1 + ADDR_WIDTH + DATA_WIDTH + BE_W + TAG_W;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_lsu_cnt;
    logic [CNT_W-1:0] r_dma_cnt;
    logic [ST_W-1:0]  r_starve_cnt;

    logic             w_lsu_elig;
    logic             w_dma_elig;
    logic             w_force_dma;
    logic             w_grant_lsu;
    logic             w_grant_dma;
    logic             w_stage_ready;
    logic             w_lsu_rd_acc;
    logic             w_dma_rd_acc;
    logic             w_lsu_rsp_hs;
    logic             w_dma_rsp_hs;
    dma_arb_src_e     w_rsp_src;
    logic [PAY_W-1:0] w_req_payload;
    logic [PAY_W-1:0] w_buf_data;

    // Reads are held back once a source has MAX_OUTSTANDING in flight; writes never are
    assign w_lsu_elig  = lsu_req_valid & (lsu_req_rw | (r_lsu_cnt < CNT_W'(MAX_OUTSTANDING)));
    assign w_dma_elig  = dma_req_valid & (dma_req_rw | (r_dma_cnt < CNT_W'(MAX_OUTSTANDING)));
    assign w_force_dma = w_dma_elig & (r_starve_cnt == ST_W'(STARVE_LIMIT));
    assign w_grant_dma = w_dma_elig & (w_force_dma | ~w_lsu_elig);
    assign w_grant_lsu = w_lsu_elig & ~w_force_dma;

    assign lsu_req_ready = w_grant_lsu & w_stage_ready;
    assign dma_req_ready = w_grant_dma & w_stage_ready;
    assign w_lsu_rd_acc  = lsu_req_valid & lsu_req_ready & ~lsu_req_rw;
    assign w_dma_rd_acc  = dma_req_valid & dma_req_ready & ~dma_req_rw;

    assign w_req_payload = w_grant_dma
        ? {dma_req_rw, dma_req_addr, dma_req_data, dma_req_byteen, 1'(SRC_DMA), dma_req_tag}
        : {lsu_req_rw, lsu_req_addr, lsu_req_data, lsu_req_byteen, 1'(SRC_LSU), lsu_req_tag};

    dma_arb_req_buf #(
        .W (PAY_W)
    ) u_req_buf (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_grant_lsu | w_grant_dma),
        .o_ready (w_stage_ready),
        .i_data  (w_req_payload),
        .o_valid (mem_req_valid),
        .i_ready (mem_req_ready),
        .o_data  (w_buf_data)
    );

    assign {mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag} = w_buf_data;

    // Responses are steered combinationally by the source bit of the returned tag
    assign w_rsp_src     = dma_arb_src_e'(mem_rsp_tag[TAG_WIDTH]);
    assign lsu_rsp_valid = mem_rsp_valid & (w_rsp_src == SRC_LSU);
    assign dma_rsp_valid = mem_rsp_valid & (w_rsp_src == SRC_DMA);
    assign mem_rsp_ready = (w_rsp_src == SRC_DMA) ? dma_rsp_ready : lsu_rsp_ready;
    assign lsu_rsp_data  = mem_rsp_data;
    assign dma_rsp_data  = mem_rsp_data;
    assign lsu_rsp_tag   = mem_rsp_tag[TAG_WIDTH-1:0];
    assign dma_rsp_tag   = mem_rsp_tag[TAG_WIDTH-1:0];
    assign w_lsu_rsp_hs  = lsu_rsp_valid & lsu_rsp_ready;
    assign w_dma_rsp_hs  = dma_rsp_valid & dma_rsp_ready;

    // DMA starvation counter: counts lost accept cycles, cleared by a DMA accept or an idle DMA
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!dma_req_valid || (w_grant_dma && w_stage_ready)) begin
            r_starve_cnt <= '0;
        end else if (w_dma_elig && w_stage_ready && (r_starve_cnt != ST_W'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Outstanding-read counters; a stray response never drives a count below zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lsu_cnt <= '0;
            r_dma_cnt <= '0;
        end else begin
            case ({w_lsu_rd_acc, w_lsu_rsp_hs && (r_lsu_cnt != '0)})
                2'b10:   r_lsu_cnt <= r_lsu_cnt + 1'b1;
                2'b01:   r_lsu_cnt <= r_lsu_cnt - 1'b1;
                default: r_lsu_cnt <= r_lsu_cnt;
            endcase
            case ({w_dma_rd_acc, w_dma_rsp_hs && (r_dma_cnt != '0)})
                2'b10:   r_dma_cnt <= r_dma_cnt + 1'b1;
                2'b01:   r_dma_cnt <= r_dma_cnt - 1'b1;
                default: r_dma_cnt <= r_dma_cnt;
            endcase
        end
    end

    a_lsu_no_underflow: assert property (@(posedge clk) disable iff (reset)
        w_lsu_rsp_hs |-> (r_lsu_cnt != '0));
    a_dma_no_underflow: assert property (@(posedge clk) disable iff (reset)
        w_dma_rsp_hs |-> (r_dma_cnt != '0));

`ifdef DMA_ARB_PERF_EN
    // Free-running performance counters, wrapping on overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lsu_grants   <= '0;
            perf_dma_grants   <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (lsu_req_valid && lsu_req_ready) begin
                perf_lsu_grants <= perf_lsu_grants + 1'b1;
            end
            if (dma_req_valid && dma_req_ready) begin
                perf_dma_grants <= perf_dma_grants + 1'b1;
            end
            if (mem_req_valid && !mem_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dma_lsu_port_arbiter.sv
// tb/tb_dma_lsu_port_arbiter.sv - scoreboard bench for the LSU/DMA port arbiter
module tb_dma_lsu_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int TW  = 8;
    localparam int TGW = TW + 1;
    localparam int BW  = DW / 8;
    localparam int SL  = 4;
    localparam int MO  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_rw = 1'b0;
    logic [AW-1:0] lsu_req_addr = '0;
    logic [DW-1:0] lsu_req_data = '0;
    logic [BW-1:0] lsu_req_byteen = '1;
    logic [TW-1:0] lsu_req_tag = '0;
    logic          dma_req_valid = 1'b0, dma_req_ready, dma_req_rw = 1'b0;
    logic [AW-1:0] dma_req_addr = '0;
    logic [DW-1:0] dma_req_data = '0;
    logic [BW-1:0] dma_req_byteen = '1;
    logic [TW-1:0] dma_req_tag = '0;
    logic          mem_req_valid, mem_req_ready = 1'b0, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [BW-1:0] mem_req_byteen;
    logic [TW:0]   mem_req_tag;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data;
    logic [TW:0]   mem_rsp_tag;
    logic          lsu_rsp_valid, lsu_rsp_ready = 1'b0;
    logic [DW-1:0] lsu_rsp_data;
    logic [TW-1:0] lsu_rsp_tag;
    logic          dma_rsp_valid, dma_rsp_ready = 1'b0;
    logic [DW-1:0] dma_rsp_data;
    logic [TW-1:0] dma_rsp_tag;
`ifdef DMA_ARB_PERF_EN
    logic [43:0]   perf_lsu_grants, perf_dma_grants, perf_stall_cycles;
`endif

    logic          auto_rsp = 1'b0;
    logic          ar_valid = 1'b0;
    logic [TGW-1:0] ar_tag = '0;
    logic          man_valid = 1'b0;
    logic [TGW-1:0] man_tag = '0;
    logic [DW-1:0] man_data = '0;

    logic [AW+TGW:0] exp_q[$];
    logic [TGW-1:0]  rsp_q[$];
    logic [AW+TGW:0] sb_e;
    int total = 0;
    int bad   = 0;

    assign mem_rsp_valid = auto_rsp ? ar_valid : man_valid;
    assign mem_rsp_tag   = auto_rsp ? ar_tag : man_tag;
    assign mem_rsp_data  = auto_rsp ? '0 : man_data;

    always #5 clk = ~clk;

    dma_lsu_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
        .STARVE_LIMIT(SL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_rw(lsu_req_rw),
        .lsu_req_addr(lsu_req_addr), .lsu_req_data(lsu_req_data), .lsu_req_byteen(lsu_req_byteen),
        .lsu_req_tag(lsu_req_tag),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_rw(dma_req_rw),
        .dma_req_addr(dma_req_addr), .dma_req_data(dma_req_data), .dma_req_byteen(dma_req_byteen),
        .dma_req_tag(dma_req_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen),
        .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
        .lsu_rsp_tag(lsu_rsp_tag),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_ready(dma_rsp_ready), .dma_rsp_data(dma_rsp_data),
        .dma_rsp_tag(dma_rsp_tag)
`ifdef DMA_ARB_PERF_EN
        ,
        .perf_lsu_grants(perf_lsu_grants), .perf_dma_grants(perf_dma_grants),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // Scoreboard and memory responder, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req_valid && mem_req_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got tag=%h addr=%h, required no request", mem_req_tag, mem_req_addr);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({mem_req_rw, mem_req_tag, mem_req_addr} !== sb_e) begin
                        bad++;
                        $display("FAIL sb_payload: got %h, required %h", {mem_req_rw, mem_req_tag, mem_req_addr}, sb_e);
                    end
                    if (auto_rsp && !mem_req_rw) rsp_q.push_back(mem_req_tag);
                end
            end
            if (lsu_req_valid && lsu_req_ready) exp_q.push_back({lsu_req_rw, 1'b0, lsu_req_tag, lsu_req_addr});
            if (dma_req_valid && dma_req_ready) exp_q.push_back({dma_req_rw, 1'b1, dma_req_tag, dma_req_addr});
            if (auto_rsp && rsp_q.size() > 0) begin
                ar_valid = 1'b1;
                ar_tag   = rsp_q.pop_front();
            end else begin
                ar_valid = 1'b0;
            end
        end else begin
            ar_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
        lsu_req_rw = 1'b0; dma_req_rw = 1'b0;
        man_valid = 1'b0; auto_rsp = 1'b0;
        lsu_rsp_ready = 1'b0; dma_rsp_ready = 1'b0; mem_req_ready = 1'b0;
        step(); step();
        exp_q.delete(); rsp_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", mem_req_valid); end
        total++; if ({dut.r_lsu_cnt, dut.r_dma_cnt, dut.r_starve_cnt} !== '0) begin bad++;
            $display("FAIL reset_counts: got %h/%h/%h, required 0", dut.r_lsu_cnt, dut.r_dma_cnt, dut.r_starve_cnt); end
        step();
    endtask

    task automatic test_starve();
        logic l_hs, d_hs, exp_dma;
        do_reset();
        auto_rsp = 1'b1; lsu_rsp_ready = 1'b1; dma_rsp_ready = 1'b1; mem_req_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_req_tag = 8'h00; lsu_req_addr = 32'h1000;
        dma_req_valid = 1'b1; dma_req_tag = 8'h80; dma_req_addr = 32'h2000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_dma = (i % 5 == 4);
            l_hs = lsu_req_valid & lsu_req_ready;
            d_hs = dma_req_valid & dma_req_ready;
            total++;
            if ({l_hs, d_hs} !== {~exp_dma, exp_dma}) begin bad++;
                $display("FAIL grant_pattern cycle %0d: got lsu/dma=%b%b, required %b%b", i, l_hs, d_hs, ~exp_dma, exp_dma); end
            if (i > 0) begin
                total++;
                if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL no_idle cycle %0d: got %b, required 1", i, mem_req_valid); end
            end
            step();
            if (l_hs) begin lsu_req_tag++; lsu_req_addr++; end
            if (d_hs) begin dma_req_tag++; dma_req_addr++; end
        end
        lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
        repeat (4) step();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL starve_drain: got %0d pending, required 0", exp_q.size()); end
        total++; if ({dut.r_lsu_cnt, dut.r_dma_cnt} !== '0) begin bad++;
            $display("FAIL starve_counts: got %h/%h, required 0", dut.r_lsu_cnt, dut.r_dma_cnt); end
        auto_rsp = 1'b0;
    endtask

    task automatic test_outstanding_cap();
        int n;
        logic hs;
        do_reset();
        mem_req_ready = 1'b1;
        dma_req_valid = 1'b1; dma_req_rw = 1'b0; dma_req_tag = 8'h40; dma_req_addr = 32'h3000;
        n = 0;
        for (int c = 0; c < 20 && n < 8; c++) begin
            @(negedge clk);
            hs = dma_req_valid & dma_req_ready;
            if (hs) n++;
            step();
            if (hs) begin dma_req_tag++; dma_req_addr++; end
        end
        total++; if (n !== 8) begin bad++; $display("FAIL cap_fill: got %0d reads, required 8", n); end
        @(negedge clk);
        total++; if (dma_req_ready !== 1'b0) begin bad++; $display("FAIL cap_block: got %b, required 0", dma_req_ready); end
        total++; if (dut.r_dma_cnt !== 4'd8) begin bad++; $display("FAIL cap_count: got %0d, required 8", dut.r_dma_cnt); end
        step();
        dma_req_rw = 1'b1;
        @(negedge clk);
        total++; if (dma_req_ready !== 1'b1) begin bad++; $display("FAIL cap_write: got %b, required 1", dma_req_ready); end
        step();
        dma_req_rw = 1'b0; dma_req_tag++;
        man_valid = 1'b1; man_tag = {1'b1, 8'h40}; dma_rsp_ready = 1'b1;
        @(negedge clk);
        total++; if ({dma_req_ready, mem_rsp_ready} !== 2'b01) begin bad++;
            $display("FAIL cap_rsp_cycle: got ready/rsp_ready=%b%b, required 01", dma_req_ready, mem_rsp_ready); end
        step();
        man_valid = 1'b0;
        @(negedge clk);
        total++; if (dma_req_ready !== 1'b1) begin bad++; $display("FAIL cap_reenable: got %b, required 1", dma_req_ready); end
        step();
        dma_req_valid = 1'b0; dma_rsp_ready = 1'b0;
        step();
        @(negedge clk);
        total++; if (dut.r_dma_cnt !== 4'd8) begin bad++; $display("FAIL cap_refill: got %0d, required 8", dut.r_dma_cnt); end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        lsu_req_valid = 1'b1; lsu_req_tag = 8'h11; lsu_req_addr = 32'hA000;
        @(negedge clk);
        total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL stall_first: got %b, required 1", lsu_req_ready); end
        step();
        lsu_req_tag = 8'h12; lsu_req_addr = 32'hA001;
        dma_req_valid = 1'b1; dma_req_tag = 8'h95; dma_req_addr = 32'hB000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({mem_req_valid, mem_req_tag, mem_req_addr, lsu_req_ready, dma_req_ready} !== {1'b1, 9'h011, 32'hA000, 2'b00}) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: got v=%b tag=%h addr=%h rdy=%b%b, required v=1 tag=011 addr=a000 rdy=00",
                         i, mem_req_valid, mem_req_tag, mem_req_addr, lsu_req_ready, dma_req_ready);
            end
            step();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        total++; if ({lsu_req_ready, dma_req_ready} !== 2'b10) begin bad++;
            $display("FAIL stall_release: got lsu/dma=%b%b, required 10", lsu_req_ready, dma_req_ready); end
        step();
        lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
        repeat (2) step();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_rsp_steer();
        do_reset();
        mem_req_ready = 1'b1;
        dma_req_valid = 1'b1; dma_req_rw = 1'b0; dma_req_tag = 8'h3A; dma_req_addr = 32'h4000;
        @(negedge clk);
        step();
        dma_req_valid = 1'b0;
        step();
        man_valid = 1'b1; man_tag = {1'b1, 8'h3A}; man_data = 64'hDEAD_BEEF_0123_4567;
        dma_rsp_ready = 1'b0; lsu_rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({dma_rsp_valid, lsu_rsp_valid, mem_rsp_ready} !== 3'b100) begin bad++;
            $display("FAIL steer_valid: got dma/lsu/rdy=%b%b%b, required 100", dma_rsp_valid, lsu_rsp_valid, mem_rsp_ready); end
        total++;
        if ({dma_rsp_tag, dma_rsp_data} !== {8'h3A, 64'hDEAD_BEEF_0123_4567}) begin bad++;
            $display("FAIL steer_payload: got tag=%h data=%h, required 3a deadbeef01234567", dma_rsp_tag, dma_rsp_data); end
        step();
        dma_rsp_ready = 1'b1;
        @(negedge clk);
        total++; if ({mem_rsp_ready, dut.r_dma_cnt} !== {1'b1, 4'd1}) begin bad++;
            $display("FAIL steer_hold: got rdy=%b cnt=%0d, required rdy=1 cnt=1", mem_rsp_ready, dut.r_dma_cnt); end
        step();
        man_valid = 1'b0; dma_rsp_ready = 1'b0;
        @(negedge clk);
        total++; if (dut.r_dma_cnt !== 4'd0) begin bad++; $display("FAIL steer_dec: got %0d, required 0", dut.r_dma_cnt); end
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_req_ready = 1'b1; lsu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_req_rw = 1'b0; lsu_req_tag = 8'h01; lsu_req_addr = 32'h6000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step();
            lsu_req_tag++; lsu_req_addr++;
        end
        man_valid = 1'b1; man_tag = {1'b0, 8'h01}; man_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        total++;
        if ({lsu_req_ready, lsu_rsp_valid, mem_rsp_ready, lsu_rsp_tag, dut.r_lsu_cnt} !== {3'b111, 8'h01, 4'd3}) begin bad++;
            $display("FAIL simul_pre: got rdy=%b rv=%b mrdy=%b tag=%h cnt=%0d, required 1 1 1 01 3",
                     lsu_req_ready, lsu_rsp_valid, mem_rsp_ready, lsu_rsp_tag, dut.r_lsu_cnt); end
        step();
        man_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        total++; if (dut.r_lsu_cnt !== 4'd3) begin bad++; $display("FAIL simul_count: got %0d, required 3", dut.r_lsu_cnt); end
        step();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        lsu_req_valid = 1'b1; lsu_req_rw = 1'b0; lsu_req_tag = 8'h21; lsu_req_addr = 32'h5000;
        step();
        dma_req_valid = 1'b1; dma_req_rw = 1'b0; dma_req_tag = 8'h91; dma_req_addr = 32'h7000;
        @(negedge clk);
        total++; if ({mem_req_valid, dut.r_lsu_cnt} !== {1'b1, 4'd1}) begin bad++;
            $display("FAIL mid_pre: got v=%b cnt=%0d, required v=1 cnt=1", mem_req_valid, dut.r_lsu_cnt); end
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        total++; if ({mem_req_valid, dut.r_lsu_cnt, dut.r_dma_cnt, dut.r_starve_cnt} !== '0) begin bad++;
            $display("FAIL mid_reset: got v=%b cnt=%0d/%0d st=%0d, required all 0",
                     mem_req_valid, dut.r_lsu_cnt, dut.r_dma_cnt, dut.r_starve_cnt); end
        exp_q.delete();
        step();
        reset = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        total++; if ({lsu_req_ready, dma_req_ready} !== 2'b10) begin bad++;
            $display("FAIL mid_first_grant: got lsu/dma=%b%b, required 10", lsu_req_ready, dma_req_ready); end
        step();
        lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_starve();
        test_outstanding_cap();
        test_stall();
        test_rsp_steer();
        test_simultaneous();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
